// File: rtl/coef_load_ctrl.sv
// Coefficient bank loader: writes a coefficient set over the shared strobe/ack
// bank port, reads every word back and reports done/error; passes host traffic through while idle.
module coef_load_ctrl #(
    parameter int DW      = 16,
    parameter int AW      = 3,
    parameter int NCOEF   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [DW*NCOEF-1:0] coefs_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                err_to_o,
    output logic [AW-1:0]       err_adr_o,
    input  logic                h_stb_i,
    input  logic                h_we_i,
    input  logic [AW-1:0]       h_adr_i,
    input  logic [DW-1:0]       h_dat_i,
    output logic                h_ack_o,
    output logic [DW-1:0]       h_dat_o,
    output logic                m_stb_o,
    output logic                m_we_o,
    output logic [AW-1:0]       m_adr_o,
    output logic [DW-1:0]       m_dat_o,
    input  logic                m_ack_i,
    input  logic [DW-1:0]       m_dat_i
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [DW-1:0]    coef_q [NCOEF];
    logic [DW-1:0]    coef_d [NCOEF];
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             err_to_q, err_to_d;
    logic [AW-1:0]    err_adr_q, err_adr_d;
    logic [DW-1:0]    cur_coef_s;
    logic             xfer_s;
    logic             last_s;

    assign cur_coef_s = coef_q[idx_q];
    assign xfer_s     = m_stb_o && m_ack_i;
    assign last_s     = (idx_q == AW'(NCOEF - 1));

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign err_to_o  = err_to_q;
    assign err_adr_o = err_adr_q;

    // Bank port mux: host passthrough in IDLE, loader drive otherwise.
    always_comb begin
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_adr_o = {AW{1'b0}};
        m_dat_o = {DW{1'b0}};
        h_ack_o = 1'b0;
        h_dat_o = {DW{1'b0}};
        case (state_q)
            S_IDLE: begin
                m_stb_o = h_stb_i;
                m_we_o  = h_we_i;
                m_adr_o = h_adr_i;
                m_dat_o = h_dat_i;
                h_ack_o = m_ack_i;
                h_dat_o = m_dat_i;
            end
            S_WRITE: begin
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_adr_o = idx_q;
                m_dat_o = cur_coef_s;
            end
            S_READ: begin
                m_stb_o = 1'b1;
                m_adr_o = idx_q;
            end
            default: begin
                m_stb_o = 1'b0;
            end
        endcase
    end

    // Next-state, index, wait counter and error flag computation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        coef_d    = coef_q;
        err_d     = err_q;
        err_to_d  = err_to_q;
        err_adr_d = err_adr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    for (int k = 0; k < NCOEF; k++) begin
                        coef_d[k] = coefs_i[DW*k +: DW];
                    end
                    err_d     = 1'b0;
                    err_to_d  = 1'b0;
                    err_adr_d = {AW{1'b0}};
                    idx_d     = {AW{1'b0}};
                    wait_d    = {WW{1'b0}};
                    state_d   = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE, S_READ: begin
                if (xfer_s) begin
                    wait_d = {WW{1'b0}};
                    // Readback mismatches are recorded but the pass runs to the end.
                    if ((state_q == S_READ) && (m_dat_i != cur_coef_s)) begin
                        err_d = 1'b1;
                        if (!err_q) begin
                            err_adr_d = idx_q;
                        end else begin
                            err_adr_d = err_adr_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    if (last_s) begin
                        idx_d   = {AW{1'b0}};
                        state_d = (state_q == S_WRITE) ? S_READ : S_DONE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    wait_d   = {WW{1'b0}};
                    err_d    = 1'b1;
                    err_to_d = 1'b1;
                    if (!err_q) begin
                        err_adr_d = idx_q;
                    end else begin
                        err_adr_d = err_adr_q;
                    end
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= {AW{1'b0}};
            wait_q    <= {WW{1'b0}};
            for (int k = 0; k < NCOEF; k++) begin
                coef_q[k] <= {DW{1'b0}};
            end
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_to_q  <= 1'b0;
            err_adr_q <= {AW{1'b0}};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            for (int k = 0; k < NCOEF; k++) begin
                coef_q[k] <= coef_d[k];
            end
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_to_q  <= err_to_d;
            err_adr_q <= err_adr_d;
        end
    end

endmodule

// File: tb/tb_coef_load_ctrl.sv
// Scoreboard bench for coef_load_ctrl: a bank model answers the bus, stimulus
// pushes expected transfers/done reports, a negedge monitor pops and compares.
module tb_coef_load_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NC = 5;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               start_i = 1'b0;
    logic [DW*NC-1:0]   coefs_i = '0;
    logic               busy_o, done_o, err_o, err_to_o;
    logic [AW-1:0]      err_adr_o;
    logic               h_stb_i = 1'b0, h_we_i = 1'b0;
    logic [AW-1:0]      h_adr_i = '0;
    logic [DW-1:0]      h_dat_i = '0;
    logic               h_ack_o;
    logic [DW-1:0]      h_dat_o;
    logic               m_stb_o, m_we_o;
    logic [AW-1:0]      m_adr_o;
    logic [DW-1:0]      m_dat_o;
    logic               m_ack_i;
    logic [DW-1:0]      m_dat_i;

    logic               corrupt_mode = 1'b0;
    logic               stall_mode = 1'b0;
    logic [DW-1:0]      bank [8];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int done_seen = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        int            cyc;
    } txn_t;

    typedef struct {
        logic          err;
        logic          to;
        logic [AW-1:0] adr;
        int            cyc;
    } done_t;

    txn_t          txq[$];
    done_t         dq[$];
    logic [DW-1:0] hq[$];
    txn_t          mt;
    done_t         md;
    logic [DW-1:0] mh;

    coef_load_ctrl #(.DW(DW), .AW(AW), .NCOEF(NC), .TIMEOUT(15)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .coefs_i(coefs_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_to_o(err_to_o),
        .err_adr_o(err_adr_o),
        .h_stb_i(h_stb_i), .h_we_i(h_we_i), .h_adr_i(h_adr_i), .h_dat_i(h_dat_i),
        .h_ack_o(h_ack_o), .h_dat_o(h_dat_o),
        .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: zero-wait ack, optional stall beyond addr 0, optional corruption of addr 2 reads.
    assign m_ack_i = m_stb_o && !(stall_mode && (m_adr_o != 3'd0));
    assign m_dat_i = (m_stb_o && !m_we_o) ?
                     ((corrupt_mode && (m_adr_o == 3'd2)) ? 16'hDEAD : bank[m_adr_o]) : 16'h0000;

    always @(posedge clk) begin
        if (rst_i) begin
            bank[0] <= 16'h00FF; bank[1] <= 16'h001F; bank[2] <= 16'h007F;
            bank[3] <= 16'h0003; bank[4] <= 16'h00FF; bank[5] <= 16'h0000;
            bank[6] <= 16'h0000; bank[7] <= 16'h0000;
        end else if (m_stb_o && m_ack_i && m_we_o) begin
            bank[m_adr_o] <= m_dat_o;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a transfer, host read or done pulse.
    always @(negedge clk) begin
        if (m_stb_o && m_ack_i) begin
            if (txq.size() == 0) begin
                chk("unexpected_txn", 1, 0);
            end else begin
                mt = txq.pop_front();
                chk("txn_we", int'(m_we_o), int'(mt.we));
                chk("txn_adr", int'(m_adr_o), int'(mt.adr));
                if (mt.we) chk("txn_wdat", int'(m_dat_o), int'(mt.dat));
                chk("txn_cyc", cyc, mt.cyc);
            end
        end
        if (h_stb_i && !h_we_i && h_ack_o) begin
            if (hq.size() == 0) begin
                chk("unexpected_hread", 1, 0);
            end else begin
                mh = hq.pop_front();
                chk("host_rdat", int'(h_dat_o), int'(mh));
            end
        end
        if (h_stb_i && busy_o) begin
            chk("busy_hack", int'(h_ack_o), 0);
            chk("busy_hdat", int'(h_dat_o), 0);
        end
        if (done_o) begin
            done_seen++;
            if (dq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                md = dq.pop_front();
                chk("done_err", int'(err_o), int'(md.err));
                chk("done_err_to", int'(err_to_o), int'(md.to));
                chk("done_err_adr", int'(err_adr_o), int'(md.adr));
                chk("done_cyc", cyc, md.cyc);
            end
        end
    end

    task automatic do_start(input logic [DW*NC-1:0] c, output int sc);
        @(posedge clk); #1;
        coefs_i = c;
        start_i = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic push_load(input logic [DW*NC-1:0] c, input int sc);
        for (int k = 0; k < NC; k++)
            txq.push_back('{we: 1'b1, adr: AW'(k), dat: c[DW*k +: DW], cyc: sc + 1 + k});
        for (int k = 0; k < NC; k++)
            txq.push_back('{we: 1'b0, adr: AW'(k), dat: 16'h0000, cyc: sc + 1 + NC + k});
    endtask

    task automatic push_done(input logic e, input logic t, input int a, input int c);
        dq.push_back('{err: e, to: t, adr: AW'(a), cyc: c});
    endtask

    task automatic host_rd(input int adr, input logic [DW-1:0] exp);
        @(posedge clk); #1;
        h_stb_i = 1'b1; h_we_i = 1'b0; h_adr_i = AW'(adr);
        txq.push_back('{we: 1'b0, adr: AW'(adr), dat: 16'h0000, cyc: cyc});
        hq.push_back(exp);
        @(posedge clk); #1;
        h_stb_i = 1'b0;
    endtask

    task automatic wait_done();
        int s = done_seen;
        int i = 0;
        while (done_seen == s && i < 200) begin
            @(posedge clk);
            i++;
        end
        chk("done_wait", int'(done_seen > s), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW*NC-1:0] c;
        int sc;
        int i;

        // 1: reset state and host passthrough read
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_err_to", int'(err_to_o), 0);
        chk("rst_err_adr", int'(err_adr_o), 0);
        chk("rst_m_stb", int'(m_stb_o), 0);
        host_rd(0, 16'h00FF);
        chk("idle_busy", int'(busy_o), 0);

        // 2: clean load, then host readback
        c = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        do_start(c, sc);
        push_load(c, sc);
        push_done(1'b0, 1'b0, 0, sc + 11);
        wait_done();
        host_rd(3, 16'h4444);

        // 3: host write held across a load completes on return to IDLE
        c = {16'h1234, 16'hF0F0, 16'h0F0F, 16'hA5A5, 16'h5A5A};
        do_start(c, sc);
        push_load(c, sc);
        push_done(1'b0, 1'b0, 0, sc + 11);
        txq.push_back('{we: 1'b1, adr: 3'd1, dat: 16'hBEEF, cyc: sc + 12});
        @(posedge clk); #1;
        h_stb_i = 1'b1; h_we_i = 1'b1; h_adr_i = 3'd1; h_dat_i = 16'hBEEF;
        i = 0;
        while (i < 40) begin
            @(negedge clk);
            if (h_ack_o) break;
            i++;
        end
        chk("hw_complete_cyc", cyc, sc + 12);
        @(posedge clk); #1;
        h_stb_i = 1'b0; h_we_i = 1'b0;
        host_rd(1, 16'hBEEF);

        // 4: corrupted readback at addr 2
        corrupt_mode = 1'b1;
        c = {16'h0505, 16'h0404, 16'h3333, 16'h0202, 16'h0101};
        do_start(c, sc);
        push_load(c, sc);
        push_done(1'b1, 1'b0, 2, sc + 11);
        wait_done();
        corrupt_mode = 1'b0;

        // 5: bank stalls from addr 1 -> timeout abort, then a clean start clears flags
        stall_mode = 1'b1;
        c = {16'h00E5, 16'h00E4, 16'h00E3, 16'h00E2, 16'h00E1};
        do_start(c, sc);
        txq.push_back('{we: 1'b1, adr: 3'd0, dat: 16'h00E1, cyc: sc + 1});
        push_done(1'b1, 1'b1, 1, sc + 17);
        wait_done();
        stall_mode = 1'b0;
        @(posedge clk); #1;
        chk("to_err_hold", int'(err_o), 1);
        chk("to_err_to_hold", int'(err_to_o), 1);
        c = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333};
        do_start(c, sc);
        chk("restart_err", int'(err_o), 0);
        chk("restart_err_to", int'(err_to_o), 0);
        chk("restart_err_adr", int'(err_adr_o), 0);
        push_load(c, sc);
        push_done(1'b0, 1'b0, 0, sc + 11);
        wait_done();

        // 6: start while busy is ignored, reset mid-load aborts without done
        c = {16'h9999, 16'h8888, 16'h7777, 16'h6666, 16'h5555};
        do_start(c, sc);
        for (int k = 0; k < 3; k++)
            txq.push_back('{we: 1'b1, adr: AW'(k), dat: c[DW*k +: DW], cyc: sc + 1 + k});
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("mrst_m_stb", int'(m_stb_o), 0);
        chk("mrst_busy", int'(busy_o), 0);
        chk("mrst_done", int'(done_o), 0);
        chk("mrst_err", int'(err_o), 0);
        repeat (20) @(posedge clk);
        host_rd(2, 16'h007F);

        repeat (2) @(posedge clk);
        chk("txq_empty", txq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        chk("hq_empty", hq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
